// File: rtl/z80_arb_pkg.sv
// Shared state type, default parameter values and counter sizing for the
// tv80s / DMA memory bus arbiter.
package z80_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    GNT  = 3'd2,
    REL  = 3'd3,
    HOLD = 3'd4
  } arb_state_t;

  localparam int unsigned DEF_MAX_BURST      = 64;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
  localparam int unsigned MAX_BURST_LIMIT    = 255;

  // Bits needed to hold the value n (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/arb_down_counter.sv
// Loadable down counter that stops at zero; used for the CPU holdoff window
// and the bus-request timeout.
module arb_down_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/z80_bus_arbiter.sv
// Shares the CPU memory between the tv80s core and one DMA requester using
// busrq_n/busak_n. Optional request timeout: define Z80_ARB_TIMEOUT_EN.
module z80_bus_arbiter
  import z80_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST      = DEF_MAX_BURST,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_mreq_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_busak_n,
  output logic        cpu_busrq_n,
  input  logic        dma_req,
  input  logic        dma_valid,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ready,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  output logic        dma_err,
  output logic [15:0] mem_a,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned BURST_W = cnt_w(MAX_BURST);
  localparam int unsigned HOLD_W  = cnt_w(HOLDOFF_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    HOLD_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  if ((MAX_BURST < 1) || (MAX_BURST > MAX_BURST_LIMIT) || (TIMEOUT_CYCLES < 1))
  begin : g_param_check
    $error("z80_bus_arbiter: MAX_BURST or TIMEOUT_CYCLES out of range");
  end

  arb_state_t         state;
  arb_state_t         state_next;
  logic [BURST_W-1:0] burst_cnt;
  logic               burst_done;
  logic               granted;
  logic               accept;
  logic               rd_accept;
  logic               rd_vld_p1;
  logic               hold_zero;
  logic               timeout_hit;

  assign granted    = (state == GNT);
  assign burst_done = (burst_cnt >= BURST_W'(MAX_BURST));
  // A read in flight blocks the next access; a vanished busak_n blocks all.
  assign dma_ready  = granted && !rd_vld_p1 && !cpu_busak_n && dma_req && !burst_done;
  assign accept     = dma_valid && dma_ready;
  assign rd_accept  = accept && !dma_we;

  arb_down_counter #(.W(HOLD_W)) u_holdoff (
    .clk      (clk),
    .reset    (reset),
    .load     (state != HOLD),
    .load_val (HOLD_LOAD),
    .en       (state == HOLD),
    .zero     (hold_zero)
  );

`ifdef Z80_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LOAD =
    TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic to_zero;

  arb_down_counter #(.W(TO_W)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (state != REQ),
    .load_val (TO_LOAD),
    .en       (state == REQ),
    .zero     (to_zero)
  );

  assign timeout_hit = (state == REQ) && dma_req && cpu_busak_n && to_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      dma_err <= 1'b0;
    end else begin
      dma_err <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign dma_err     = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dma_req) state_next = REQ;
      end
      REQ: begin
        if (!dma_req)          state_next = REL;
        else if (!cpu_busak_n) state_next = GNT;
        else if (timeout_hit)  state_next = HOLD;
      end
      GNT: begin
        // Releasing with a read in flight is safe: its rvalid is this cycle.
        if (cpu_busak_n)                state_next = HOLD;
        else if (!dma_req || burst_done) state_next = REL;
      end
      REL: begin
        if (cpu_busak_n) state_next = HOLD;
      end
      HOLD: begin
        if (hold_zero) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p0 -> p1: state, bus request, burst count and read-valid register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cpu_busrq_n <= 1'b1;
      rd_vld_p1   <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      state       <= state_next;
      cpu_busrq_n <= !((state_next == REQ) || (state_next == GNT));
      rd_vld_p1   <= rd_accept;
      if ((state != GNT) && (state_next == GNT)) begin
        burst_cnt <= '0;
      end else if (accept && (burst_cnt != {BURST_W{1'b1}})) begin
        burst_cnt <= burst_cnt + BURST_W'(1);
      end
    end
  end

  assign dma_rvalid = rd_vld_p1;
  assign dma_rdata  = mem_rdata;

  always_comb begin
    if (granted) begin
      mem_a     = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = accept && dma_we;
    end else begin
      mem_a     = cpu_a;
      mem_wdata = cpu_do;
      mem_we    = !cpu_mreq_n && !cpu_wr_n;
    end
  end

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Scoreboard bench for z80_bus_arbiter: bench-side memory and busak_n model,
// expected read data queued at acceptance and compared on dma_rvalid.
module tb_z80_bus_arbiter;
  import z80_arb_pkg::*;

  localparam int unsigned MAX_BURST      = 4;
  localparam int unsigned HOLDOFF_CYCLES = 16;
  localparam int unsigned TIMEOUT_CYCLES = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_a = 16'h0000;
  logic [7:0]  cpu_do = 8'h00;
  logic        cpu_mreq_n = 1'b1;
  logic        cpu_wr_n = 1'b1;
  logic        cpu_busak_n = 1'b1;
  logic        cpu_busrq_n;
  logic        dma_req = 1'b0;
  logic        dma_valid = 1'b0;
  logic        dma_we = 1'b0;
  logic [15:0] dma_addr = 16'h0000;
  logic [7:0]  dma_wdata = 8'h00;
  logic        dma_ready;
  logic        dma_rvalid;
  logic [7:0]  dma_rdata;
  logic        dma_err;
  logic [15:0] mem_a;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [7:0]  exp_q[$];

  int checks = 0;
  int failures = 0;
  int ack_delay = 4;
  bit ack_stuck = 1'b0;
  int ack_cnt = 0;
  int hi_run = 0;
  int last_hi_run = 0;

  z80_bus_arbiter #(
    .MAX_BURST      (MAX_BURST),
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_a       (cpu_a),
    .cpu_do      (cpu_do),
    .cpu_mreq_n  (cpu_mreq_n),
    .cpu_wr_n    (cpu_wr_n),
    .cpu_busak_n (cpu_busak_n),
    .cpu_busrq_n (cpu_busrq_n),
    .dma_req     (dma_req),
    .dma_valid   (dma_valid),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_ready   (dma_ready),
    .dma_rvalid  (dma_rvalid),
    .dma_rdata   (dma_rdata),
    .dma_err     (dma_err),
    .mem_a       (mem_a),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory with registered read data.
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_a] <= mem_wdata;
    mem_rdata <= mem[mem_a];
  end

  // CPU side: acknowledge a held request after ack_delay cycles, drop on release.
  always @(negedge clk) begin
    if (cpu_busrq_n !== 1'b0) begin
      ack_cnt = 0;
      cpu_busak_n = 1'b1;
    end else if (!ack_stuck) begin
      if (ack_cnt >= ack_delay) cpu_busak_n = 1'b0;
      else ack_cnt++;
    end
  end

  // Length of the most recent completed run of busrq_n high.
  always @(negedge clk) begin
    #1;
    if (cpu_busrq_n === 1'b1) begin
      hi_run++;
    end else begin
      if (hi_run != 0) last_hi_run = hi_run;
      hi_run = 0;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Read-data scoreboard.
  always @(negedge clk) begin
    #2;
    if (dma_rvalid === 1'b1) begin
      chk_eq("rvalid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk_eq("rdata", 32'(dma_rdata), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic dma_access(input logic we, input logic [15:0] a, input logic [7:0] d,
                            input int budget, output bit acc);
    acc = 1'b0;
    for (int i = 0; (i < budget) && !acc; i++) begin
      @(negedge clk);
      dma_valid = 1'b1;
      dma_we    = we;
      dma_addr  = a;
      dma_wdata = d;
      #1;
      if (dma_ready === 1'b1) begin
        acc = 1'b1;
        if (we) begin
          chk_eq("mem_we_on_write", 32'(mem_we), 32'd1);
          chk_eq("mem_a_on_write", 32'(mem_a), 32'(a));
          ref_mem[a] = d;
        end else begin
          exp_q.push_back(ref_mem[a]);
        end
      end
    end
  endtask

  task automatic wait_busrq(input logic lvl, input int budget, output int n);
    n = 0;
    while ((cpu_busrq_n !== lvl) && (n < budget)) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    bit acc;
    int n;
    int err_at;
    int err_cnt;
    logic rq_at_err;

    // Reset and CPU pass-through
    repeat (3) @(negedge clk);
    #1;
    chk_eq("rst_busrq_n", 32'(cpu_busrq_n), 32'd1);
    chk_eq("rst_mem_a", 32'(mem_a), 32'h0000);
    chk_eq("rst_dma_ready", 32'(dma_ready), 32'd0);
    chk_eq("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    chk_eq("rst_dma_err", 32'(dma_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cpu_a = 16'h1234; cpu_do = 8'ha5; cpu_mreq_n = 1'b0; cpu_wr_n = 1'b0;
    #1;
    chk_eq("cpu_mem_a", 32'(mem_a), 32'h1234);
    chk_eq("cpu_mem_we", 32'(mem_we), 32'd1);
    chk_eq("cpu_mem_wdata", 32'(mem_wdata), 32'h00a5);
    @(negedge clk);
    cpu_mreq_n = 1'b1; cpu_wr_n = 1'b1;

    // Request, grant after ack delay, single write
    dma_req = 1'b1;
    @(negedge clk);
    #1;
    chk_eq("req_busrq_n", 32'(cpu_busrq_n), 32'd0);
    chk_eq("req_no_ready", 32'(dma_ready), 32'd0);
    dma_access(1'b1, 16'hdca6, 8'h49, 20, acc);
    chk_eq("wr_accepted", 32'(acc), 32'd1);
    @(negedge clk);
    dma_valid = 1'b0;
    #1;
    chk_eq("wr_mem_we_one_cycle", 32'(mem_we), 32'd0);
    chk_eq("wr_mem_content", 32'(mem[16'hdca6]), 32'h0049);

    // Read back: rvalid next cycle, no ready while it is pending
    dma_access(1'b0, 16'hdca6, 8'h00, 4, acc);
    chk_eq("rd_accepted", 32'(acc), 32'd1);
    @(negedge clk);
    dma_valid = 1'b0;
    #1;
    chk_eq("rd_ready_low", 32'(dma_ready), 32'd0);
    chk_eq("rd_rvalid", 32'(dma_rvalid), 32'd1);
    @(negedge clk);
    #1;
    chk_eq("rd_ready_back", 32'(dma_ready), 32'd1);
    chk_eq("rd_rvalid_pulse", 32'(dma_rvalid), 32'd0);

    dma_req = 1'b0;
    wait_busrq(1'b1, 10, n);
    chk_eq("release_busrq", 32'(cpu_busrq_n), 32'd1);
    repeat (25) @(negedge clk);

    // Burst limit, holdoff and regrant
    dma_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dma_access(1'b1, 16'h0100 + 16'(i), 8'h10 + 8'(i), (i == 0) ? 30 : 2, acc);
      chk_eq("burst_wr_acc", 32'(acc), 32'd1);
    end
    dma_access(1'b1, 16'h0104, 8'h14, 3, acc);
    chk_eq("burst_limit_block", 32'(acc), 32'd0);
    dma_access(1'b1, 16'h0104, 8'h14, 60, acc);
    chk_eq("regrant_wr_acc", 32'(acc), 32'd1);
    dma_access(1'b1, 16'h0105, 8'h15, 3, acc);
    chk_eq("regrant_wr2_acc", 32'(acc), 32'd1);
    chk_eq("holdoff_run_ge", 32'(last_hi_run >= int'(HOLDOFF_CYCLES)), 32'd1);
    @(negedge clk);
    dma_valid = 1'b0;
    #1;
    chk_eq("burst_mem_103", 32'(mem[16'h0103]), 32'h0013);
    chk_eq("burst_mem_104", 32'(mem[16'h0104]), 32'h0014);
    chk_eq("burst_mem_105", 32'(mem[16'h0105]), 32'h0015);

    // Reset in the cycle a read is accepted
    dma_access(1'b0, 16'h0103, 8'h00, 3, acc);
    chk_eq("rst_rd_acc", 32'(acc), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk_eq("midrd_busrq_n", 32'(cpu_busrq_n), 32'd1);
    chk_eq("midrd_rvalid", 32'(dma_rvalid), 32'd0);
    chk_eq("midrd_ready", 32'(dma_ready), 32'd0);
    chk_eq("midrd_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    dma_valid = 1'b0;
    dma_req = 1'b0;
    repeat (3) @(negedge clk);

    // Stuck busak_n: timeout when enabled, indefinite wait otherwise
    ack_stuck = 1'b1;
    dma_req = 1'b1;
    wait_busrq(1'b0, 5, n);
    chk_eq("to_req_busrq", 32'(cpu_busrq_n), 32'd0);
    err_at = -1;
    err_cnt = 0;
    rq_at_err = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      #1;
      if (dma_err === 1'b1) begin
        err_cnt++;
        if (err_at < 0) begin
          err_at = k;
          rq_at_err = cpu_busrq_n;
        end
      end
    end
`ifdef Z80_ARB_TIMEOUT_EN
    chk_eq("to_err_cycle", 32'(err_at), 32'd8);
    chk_eq("to_err_pulses", 32'(err_cnt), 32'd1);
    chk_eq("to_busrq_released", 32'(rq_at_err), 32'd1);
`else
    chk_eq("noto_err_cycle", 32'(err_at), 32'hffff_ffff);
    chk_eq("noto_busrq_held", 32'(cpu_busrq_n), 32'd0);
`endif
    dma_req = 1'b0;
    ack_stuck = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    chk_eq("end_busrq_n", 32'(cpu_busrq_n), 32'd1);
    chk_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
